// File: rtl/fir_l3_output_serializer.sv
// Purpose: buffers up to two LANES-wide blocks of FIR results, requantizes each lane, emits one sample per cycle.
// Latency: block accepted at edge E, lane0 valid after edge E+1; later lanes follow one per cycle.
// Backpressure: s_ready = FIFO not full (registered count only); output register holds while m_valid & !m_ready.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_data   block input; lane0 (oldest sample) in s_data[IN_WIDTH-1:0]
//   m_valid/m_ready/m_data   requantized sample stream, lane order
//   m_last                   m_data is lane LANES-1 of its block
//   m_sat                    m_data was clamped
//   sat_clear, sat_sticky    sticky clamp flag and its clear (a set on the same edge wins)
module fir_l3_output_serializer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int LANES     = 3,
    parameter int SHIFT     = 30,
    parameter int SATURATE  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [LANES*IN_WIDTH-1:0] s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [OUT_WIDTH-1:0]      m_data,
    output logic                      m_last,
    output logic                      m_sat,
    input  logic                      sat_clear,
    output logic                      sat_sticky
);

    localparam int BLK_W = LANES * IN_WIDTH;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    // Rounding constant 2^(SHIFT-1), which collapses to 0 when SHIFT is 0.
    localparam logic signed [IN_WIDTH:0] RND = ((IN_WIDTH+1)'(1) << SHIFT) >> 1;
    // Output range limits, sign-extended to the IN_WIDTH+1 working width.
    localparam logic signed [IN_WIDTH:0] Q_MAX =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] Q_MIN =
        {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Two-entry block FIFO
    logic [BLK_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic [IDX_W-1:0] idx;

    logic wr_en;
    logic load;
    logic last_lane;
    logic pop;

    logic [BLK_W-1:0]           head_blk;
    logic [IN_WIDTH-1:0]        head_lane;
    logic signed [IN_WIDTH:0]   q_round;
    logic signed [IN_WIDTH:0]   q_shift;
    logic [OUT_WIDTH-1:0]       q_dat;
    logic                       q_sat;

    // Gated by reset so the source sees no room while the buffer is being flushed.
    assign s_ready   = !reset && (count != 2'd2);
    assign wr_en     = s_valid && s_ready;
    assign load      = (!m_valid || m_ready) && (count != 2'd0);
    assign last_lane = (idx == LAST_IDX);
    // The head block leaves the FIFO on the edge its final lane enters the output register.
    assign pop       = load && last_lane;

    always_comb begin
        head_blk  = mem[rd_ptr];
        head_lane = head_blk[IN_WIDTH-1:0];
        for (int i = 0; i < LANES; i++) begin
            if (idx == IDX_W'(i)) begin
                head_lane = head_blk[i*IN_WIDTH +: IN_WIDTH];
            end
        end
        // One guard bit keeps x + 2^(SHIFT-1) from overflowing.
        q_round = $signed({head_lane[IN_WIDTH-1], head_lane}) + RND;
        q_shift = q_round >>> SHIFT;
        q_dat   = q_shift[OUT_WIDTH-1:0];
        q_sat   = 1'b0;
        if (SATURATE != 0) begin
            if (q_shift > Q_MAX) begin
                q_dat = Q_MAX[OUT_WIDTH-1:0];
                q_sat = 1'b1;
            end else if (q_shift < Q_MIN) begin
                q_dat = Q_MIN[OUT_WIDTH-1:0];
                q_sat = 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by count, and wr_en is already low in reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            idx        <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_sat      <= 1'b0;
            sat_sticky <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (load) begin
                idx     <= last_lane ? '0 : idx + IDX_W'(1);
                m_valid <= 1'b1;
                m_data  <= q_dat;
                m_last  <= last_lane;
                m_sat   <= q_sat;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (load && q_sat) begin
                sat_sticky <= 1'b1;
            end else if (sat_clear) begin
                sat_sticky <= 1'b0;
            end
        end
    end

endmodule
